uart_msg_tx: RTL and testbench
==============================

Name: uart_msg_tx

Overview:
- Byte-stream UART transmitter downstream of the board-level `top` design.
- Consumes status/debug bytes produced inside `top` and serialises them onto the Nexys A7 USB-UART TX pin.
- Frame format is 8N1, LSB first, with an internal FIFO absorbing bursts.
- Single clock domain on the 100 MHz board clock.

Parameters:
- CLK_FREQ_HZ, 100_000_000, input clock frequency in Hz.
- BAUD_RATE, 115_200, serial bit rate.
- FIFO_DEPTH, 16, byte FIFO entries; power of two, >= 2.

Ports:
- sys_clock_0  input  1  system clock; all logic on its rising edge.
- reset_0  input  1  asynchronous, active-low reset.
- in_data  input  8  byte to transmit.
- in_valid  input  1  in_data valid.
- in_ready  output  1  FIFO can accept; equals !full.
- tx  output  1  serial line; idles high.
- busy  output  1  FIFO non-empty or frame in progress.
- fifo_count  output  $clog2(FIFO_DEPTH+1)  bytes currently held in the FIFO.

Behaviour:
- CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE, integer truncation; 868 at defaults. Elaboration $error if CLKS_PER_BIT < 2 or FIFO_DEPTH is not a power of two.
- Reset (reset_0 low): asynchronous. tx=1, busy=0, fifo_count=0, FIFO pointers cleared, FSM=IDLE, bit and baud counters=0. in_ready=1 while in reset and after it.
- Handshake: a byte is accepted on a rising edge with in_valid && in_ready. in_data must hold while in_valid is high and in_ready is low.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the optional feature is enabled).
  - IDLE: tx=1. If the FIFO is non-empty, pop into the shift register on the same edge and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: shift register LSB on tx, CLKS_PER_BIT cycles per bit, 8 bits, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
  - On the last STOP cycle: if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- tx is registered (no glitches).
- Latency: byte accepted into an empty FIFO at edge k while IDLE → tx falls at edge k+1. Full frame is 10*CLKS_PER_BIT cycles.
- FIFO boundaries:
  - Push when full: impossible (in_ready=0).
  - Push and pop on the same edge, non-full: count unchanged, data order preserved.
  - in_ready derives from registered count, so a same-cycle pop does not open the FIFO for a push.
  - Pointers wrap modulo FIFO_DEPTH.
- busy = (state != IDLE) || (fifo_count != 0). It deasserts on the edge the final STOP bit ends with an empty FIFO.
- Reset mid-frame: the frame is truncated, tx returns high immediately, queued bytes are discarded, nothing is resent after release.

Optional Feature:
- Macro: UART_MSG_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles. Frame = 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state, 8N1 only, 10-bit frames.

Decomposition:
- uart_msg_pkg holds:
  - the state enum typedef (tx_state_t);
  - the function clks_per_bit(clk_hz, baud);
  - the constants DATA_BITS=8, STOP_BITS=1.
- Sub-module sync_fifo (parameterised width/depth, registered count, full/empty flags) instantiated once; FSM, baud counter and shift register stay in uart_msg_tx.

Test Plan:
- Reset: reset_0 low for 2 cycles → tx=1, busy=0, fifo_count=0, in_ready=1; all stable for 100 cycles with in_valid=0.
- Single byte, CLK_FREQ_HZ=1_000_000, BAUD_RATE=100_000 (10 clk/bit): push 0x55 → tx low from next edge for 10 cycles, then 1,0,1,0,1,0,1,0 at 10 cycles each, stop high 10 cycles; busy drops exactly 100 cycles after tx fell.
- Back-to-back: push 0xA3, 0x0F on consecutive cycles → second start bit begins exactly 100 cycles after the first; decoded bytes 0xA3, 0x0F in order.
- Full FIFO: hold in_valid high with an incrementing byte from 0x00, FIFO_DEPTH=16 → exactly 17 bytes accepted before in_ready first falls. in_ready reasserts one cycle after each pop. All bytes emerge in order with no inter-frame gap.
- Reset mid-frame: assert reset_0 during data bit 3 with 5 bytes queued → tx=1 asynchronously, fifo_count=0. After release, tx stays high 2000 cycles.
- UART_MSG_TX_PARITY_EN defined: push 0x07 → parity bit 1. Push 0x03 → parity bit 0. Frame length 110 cycles.

Source files
------------

// File: rtl/uart_msg_pkg.sv
// Shared types and helpers for the uart_msg_tx byte-stream transmitter.
// Optional macro UART_MSG_TX_PARITY_EN adds the even-parity state to the enum.
package uart_msg_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

`ifdef UART_MSG_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;
`endif

  // Integer clock cycles per serial bit (truncating division).
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count and full/empty flags.
// Pointers wrap naturally because DEPTH is a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Flags come from the registered count, so a pop never opens room for a same-edge push.
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == CNT_W'(0));
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage write; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= PTR_W'(0);
      rd_ptr <= PTR_W'(0);
      count  <= CNT_W'(0);
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_msg_tx.sv
// UART transmitter (8N1, LSB first) fed by an internal byte FIFO.
// Define UART_MSG_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_msg_tx
  import uart_msg_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                              sys_clock_0,
  input  logic                              reset_0,
  input  logic [7:0]                        in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic                              tx,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int CPB   = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int BIT_W = $clog2(DATA_BITS);

  if (CPB < 2) begin : g_bad_cpb
    $error("uart_msg_tx: CLK_FREQ_HZ/BAUD_RATE must give at least 2 clocks per bit");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_msg_tx: FIFO_DEPTH must be a power of two >= 2");
  end
  if (STOP_BITS != 1) begin : g_bad_stop
    $error("uart_msg_tx: only one stop bit is supported");
  end

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [7:0]           fifo_data;
  logic                 pop;

  tx_state_t            state, state_n;
  logic [CNT_W-1:0]     baud_cnt, baud_n;
  logic [BIT_W-1:0]     bit_cnt, bit_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 tx_n;
  logic                 last_tick;
`ifdef UART_MSG_TX_PARITY_EN
  logic                 par, par_n;
`endif

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (sys_clock_0),
    .rst_n     (reset_0),
    .push      (in_valid),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign in_ready  = !fifo_full;
  assign busy      = (state != ST_IDLE) || !fifo_empty;
  assign last_tick = (baud_cnt == CNT_W'(CPB - 1));

  // Next-state, counter, shift register and next tx level; tx itself is registered below.
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    shift_n = shift;
    tx_n    = tx;
    pop     = 1'b0;
`ifdef UART_MSG_TX_PARITY_EN
    par_n   = par;
`endif
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_n = fifo_data;
`ifdef UART_MSG_TX_PARITY_EN
          par_n   = ^fifo_data;
`endif
          baud_n  = CNT_W'(0);
          state_n = ST_START;
          tx_n    = 1'b0;
        end else begin
          tx_n    = 1'b1;
        end
      end
      ST_START: begin
        if (last_tick) begin
          baud_n  = CNT_W'(0);
          bit_n   = BIT_W'(0);
          state_n = ST_DATA;
          tx_n    = shift[0];
        end else begin
          baud_n  = baud_cnt + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (last_tick) begin
          baud_n = CNT_W'(0);
          if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
`ifdef UART_MSG_TX_PARITY_EN
            state_n = ST_PARITY;
            tx_n    = par;
`else
            state_n = ST_STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            bit_n   = bit_cnt + BIT_W'(1);
            shift_n = {1'b0, shift[DATA_BITS-1:1]};
            tx_n    = shift[1];
          end
        end else begin
          baud_n = baud_cnt + CNT_W'(1);
        end
      end
`ifdef UART_MSG_TX_PARITY_EN
      ST_PARITY: begin
        if (last_tick) begin
          baud_n  = CNT_W'(0);
          state_n = ST_STOP;
          tx_n    = 1'b1;
        end else begin
          baud_n  = baud_cnt + CNT_W'(1);
        end
      end
`endif
      ST_STOP: begin
        if (last_tick) begin
          baud_n = CNT_W'(0);
          // Chain straight into the next start bit when more data is waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_n = fifo_data;
`ifdef UART_MSG_TX_PARITY_EN
            par_n   = ^fifo_data;
`endif
            state_n = ST_START;
            tx_n    = 1'b0;
          end else begin
            state_n = ST_IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          baud_n = baud_cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        baud_n  = CNT_W'(0);
        bit_n   = BIT_W'(0);
        tx_n    = 1'b1;
      end
    endcase
  end

  // Transmitter state registers; reset drives the line high immediately.
  always_ff @(posedge sys_clock_0 or negedge reset_0) begin
    if (!reset_0) begin
      state    <= ST_IDLE;
      baud_cnt <= CNT_W'(0);
      bit_cnt  <= BIT_W'(0);
      shift    <= '0;
      tx       <= 1'b1;
`ifdef UART_MSG_TX_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
      tx       <= tx_n;
`ifdef UART_MSG_TX_PARITY_EN
      par      <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_msg_tx.sv
// Self-checking bench for uart_msg_tx: frame-timeline reference model with a
// per-cycle compare, directed literal checks and randomized traffic.
module tb_uart_msg_tx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int CPB    = 10;
  localparam int DEPTH  = 16;
`ifdef UART_MSG_TX_PARITY_EN
  localparam int NBITS  = 11;
`else
  localparam int NBITS  = 10;
`endif
  localparam int FRAME  = NBITS * CPB;

  logic       clk = 1'b0;
  logic       reset_0 = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       tx;
  logic       busy;
  logic [4:0] fifo_count;

  uart_msg_tx #(
    .CLK_FREQ_HZ (CLK_HZ),
    .BAUD_RATE   (BAUD),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .sys_clock_0 (clk),
    .reset_0     (reset_0),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .tx          (tx),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: bytes waiting + frame in flight ----------------
  logic [7:0] m_q[$];
  bit         m_active = 1'b0;
  int         m_off = 0;
  logic [7:0] m_byte = 8'h00;

  initial begin
    forever begin
      bit acc;
      @(posedge clk or negedge reset_0);
      if (!reset_0) begin
        m_q.delete();
        m_active = 1'b0;
        m_off = 0;
      end else begin
        acc = in_valid && (m_q.size() < DEPTH);
        if (m_active) begin
          m_off++;
          if (m_off == FRAME) begin
            if (m_q.size() != 0) begin
              m_byte = m_q.pop_front();
              m_off = 0;
            end else begin
              m_active = 1'b0;
            end
          end
        end else if (m_q.size() != 0) begin
          m_byte = m_q.pop_front();
          m_active = 1'b1;
          m_off = 0;
        end
        if (acc) m_q.push_back(in_data);
      end
    end
  end

  function automatic logic exp_tx();
    int idx;
    if (!m_active) return 1'b1;
    idx = m_off / CPB;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return m_byte[idx-1];
`ifdef UART_MSG_TX_PARITY_EN
    if (idx == 9) return ^m_byte;
`endif
    return 1'b1;
  endfunction

  // Compare every output against the model once per cycle, away from the clock edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("tx", 32'(tx), 32'(exp_tx()));
      chk("busy", 32'(busy), 32'(m_active || (m_q.size() != 0)));
      chk("fifo_count", 32'(fifo_count), 32'(m_q.size()));
      chk("in_ready", 32'(in_ready), 32'(m_q.size() < DEPTH));
    end
  end

  // ---------------- helpers ----------------
  logic hist [0:399];

  task automatic capture(input int from, input int to);
    for (int i = from; i < to; i++) begin
      @(negedge clk);
      hist[i] = tx;
    end
  endtask

  function automatic int find_low(input int from);
    for (int i = from; i < 400; i++) if (hist[i] == 1'b0) return i;
    return -1;
  endfunction

  function automatic logic [7:0] decode(input int f);
    logic [7:0] b;
    b = 8'h00;
    if (f < 0 || f + 90 >= 400) return 8'hxx;
    for (int i = 0; i < 8; i++) b[i] = hist[f + CPB*(i+1) + CPB/2];
    return b;
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'(0));
    @(negedge clk);
  endtask

  // Two bytes on consecutive cycles: gap between start bits and decoded values.
  task automatic pair_test(input logic [7:0] a, input logic [7:0] b,
                           input logic pa, input logic pb);
    int f0, f1;
    wait_idle();
    in_valid = 1'b1;
    in_data  = a;
    @(negedge clk);
    in_data  = b;
    hist[0]  = tx;
    @(negedge clk);
    in_valid = 1'b0;
    hist[1]  = tx;
    capture(2, 300);
    f0 = find_low(0);
    f1 = (f0 < 0) ? -1 : find_low(f0 + FRAME - 5);
    chk("pair_first_fall", 32'(f0), 32'(1));
    chk("pair_gap", 32'(f1 - f0), 32'(FRAME));
    chk("pair_byte0", 32'(decode(f0)), 32'(a));
    chk("pair_byte1", 32'(decode(f1)), 32'(b));
`ifdef UART_MSG_TX_PARITY_EN
    if (f0 >= 0 && f1 >= 0) begin
      chk("pair_parity0", 32'(hist[f0 + 95]), 32'(pa));
      chk("pair_parity1", 32'(hist[f1 + 95]), 32'(pb));
    end else begin
      chk("pair_parity_found", 32'(0), 32'(1));
    end
`else
    if (pa !== pb && a === b) chk("pair_args", 32'(pa), 32'(pb));
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0] fb;
    logic [7:0] nxt;
    int first_block, lows;
    logic r;

    // Reset held for two clocks.
    reset_0 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tx", 32'(tx), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_count", 32'(fifo_count), 32'(0));
    chk("rst_ready", 32'(in_ready), 32'(1));
    cmp_en  = 1'b1;
    reset_0 = 1'b1;
    repeat (100) @(negedge clk);
    chk("idle_tx", 32'(tx), 32'(1));
    chk("idle_busy", 32'(busy), 32'(0));

    // Single byte 0x55: literal bit pattern, start bit at index 0.
    fb = 10'b1010101010;
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(negedge clk);
    in_valid = 1'b0;
    for (int j = 0; j <= FRAME; j++) begin
      @(negedge clk);
      if (j < 90) chk("b55_bit", 32'(tx), 32'(fb[j/10]));
      if (j == FRAME - 1) begin
        chk("b55_stop", 32'(tx), 32'(1));
        chk("b55_busy_hi", 32'(busy), 32'(1));
      end
      if (j == FRAME) chk("b55_busy_lo", 32'(busy), 32'(0));
    end

    // Back-to-back bytes; parity build also checks 0x07 -> 1 and 0x03 -> 0.
    pair_test(8'hA3, 8'h0F, 1'b0, 1'b0);
`ifdef UART_MSG_TX_PARITY_EN
    pair_test(8'h07, 8'h03, 1'b1, 1'b0);
`endif

    // Full FIFO: incrementing bytes with in_valid held high.
    wait_idle();
    nxt = 8'h00;
    first_block = -1;
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      r = in_ready;
      if (!r && first_block < 0) first_block = int'(nxt);
      in_valid = 1'b1;
      in_data  = nxt;
      @(posedge clk);
      if (r) nxt = nxt + 8'd1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("full_accept_count", 32'(first_block), 32'(17));
    wait_idle();

    // Reset during data bit 3 of 0x11 with five bytes queued behind it.
    in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_data = 8'h11 + 8'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (40) @(negedge clk);
    chk("mid_pre_tx", 32'(tx), 32'(0));
    chk("mid_pre_count", 32'(fifo_count), 32'(5));
    #2 reset_0 = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx), 32'(1));
    chk("mid_rst_count", 32'(fifo_count), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_ready", 32'(in_ready), 32'(1));
    repeat (2) @(negedge clk);
    reset_0 = 1'b1;
    lows = 0;
    repeat (2000) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("post_rst_quiet", 32'(lows), 32'(0));

    // Random traffic alternating bursty and sparse segments.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (!(in_valid && !in_ready)) begin
        in_valid = ($urandom_range(0, ((c / 500) % 2 == 1) ? 2 : 80) == 0);
        in_data  = 8'($urandom);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle();
    chk("end_count", 32'(fifo_count), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
